// File: rtl/counter_pkg.sv
// Shared counter constants: mode and direction encodings used by the
// up/down counter, the prescaler and the display users.
package counter_pkg;
  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;
  localparam bit CNT_DOWN = 1'b0;
  localparam bit CNT_UP   = 1'b1;
endpackage

// File: rtl/mod_counter_ud.sv
// Up/down modulo-(MAX+1) counter with set/load/count priority, wrap-or-saturate
// mode, combinational terminal count and a registered wrap pulse for cascading.
module mod_counter_ud
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MAX      = (longint'(1) << WIDTH) - 1,
  parameter bit     SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             cnt,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter_ud: WIDTH must be in 2..32");
  end
  if (MAX == 0 || MAX >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("mod_counter_ud: MAX must satisfy 1 <= MAX <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Q never exceeds MAXV, so equality tests stand in for the range tests.
  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (set) begin
      q_nxt = MAXV;
    end else if (load) begin
      q_nxt = (din > MAXV) ? MAXV : din;
    end else if (cnt) begin
      if (up == CNT_UP) begin
        if (Q != MAXV) begin
          q_nxt = Q + WIDTH'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (Q != '0) begin
          q_nxt = Q - WIDTH'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q_nxt    = MAXV;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign tc = cnt & ((up == CNT_UP) ? (Q == MAXV) : (Q == '0));

endmodule

// File: tb/tb_mod_counter_ud.sv
// Bench for mod_counter_ud: decade wrap instance and 8-bit saturating instance,
// directed scenarios plus randomized traffic against an arithmetic model.
module tb_mod_counter_ud;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       a_set, a_load, a_cnt, a_up, a_tc, a_wrap;
  logic [3:0] a_din, a_q;
  logic       b_set, b_load, b_cnt, b_up, b_tc, b_wrap;
  logic [7:0] b_din, b_q;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_counter_ud #(.WIDTH(4), .MAX(9), .SATURATE(CNT_WRAP)) u_a (
    .clk(clk), .clear_n(clear_n), .set(a_set), .load(a_load), .din(a_din),
    .cnt(a_cnt), .up(a_up), .Q(a_q), .tc(a_tc), .wrap(a_wrap));

  mod_counter_ud #(.WIDTH(8), .MAX(200), .SATURATE(CNT_SAT)) u_b (
    .clk(clk), .clear_n(clear_n), .set(b_set), .load(b_load), .din(b_din),
    .cnt(b_cnt), .up(b_up), .Q(b_q), .tc(b_tc), .wrap(b_wrap));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_set = 0; a_load = 0; a_cnt = 0; a_up = 0; a_din = '0;
  endtask

  task automatic idle_b();
    b_set = 0; b_load = 0; b_cnt = 0; b_up = 0; b_din = '0;
  endtask

  // Reference: count range 0..maxv, modular or clamped at the ends.
  function automatic void model(input int maxv, input bit sat, input bit s, input bit l,
                                input bit c, input bit u, input int d,
                                inout int q, output bit w);
    int nq;
    w = 0;
    if (s) q = maxv;
    else if (l) q = (d > maxv) ? maxv : d;
    else if (c) begin
      nq = u ? q + 1 : q - 1;
      if (nq > maxv || nq < 0) begin
        if (sat) q = (nq < 0) ? 0 : maxv;
        else begin q = (nq + maxv + 1) % (maxv + 1); w = 1; end
      end else q = nq;
    end
  endfunction

  task automatic test_reset();
    clear_n = 0; idle_a(); idle_b();
    a_cnt = 1; a_up = 0;
    #2;
    n_chk++; if (a_q !== 4'd0 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: Q=%0d wrap=%b, want Q=0 wrap=0", a_q, a_wrap); end
    n_chk++; if (a_tc !== 1'b1) begin
      n_fail++; $display("FAIL reset_tc_down: tc=%b, want 1", a_tc); end
    a_up = 1; #1;
    n_chk++; if (a_tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc_up: tc=%b, want 0", a_tc); end
    n_chk++; if (b_q !== 8'd0 || b_wrap !== 1'b0) begin
      n_fail++; $display("FAIL reset_state_b: Q=%0d wrap=%b, want 0 0", b_q, b_wrap); end
    idle_a();
  endtask

  task automatic test_set();
    clear_n = 1;
    tick();
    n_chk++; if (a_q !== 4'd0) begin
      n_fail++; $display("FAIL idle_hold: Q=%0d, want 0", a_q); end
    a_set = 1; tick(); a_set = 0;
    n_chk++; if (a_q !== 4'd9 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL set_preset: Q=%0d wrap=%b, want Q=9 wrap=0", a_q, a_wrap); end
  endtask

  task automatic test_decade_up();
    a_load = 1; a_din = 0; tick(); a_load = 0;
    for (int k = 1; k <= 10; k++) begin
      a_cnt = 1; a_up = 1; #1;
      n_chk++; if (a_tc !== (k == 10)) begin
        n_fail++; $display("FAIL decade_tc[%0d]: tc=%b, want %b", k, a_tc, (k == 10)); end
      tick();
      n_chk++; if (int'(a_q) !== k % 10 || a_wrap !== (k == 10)) begin
        n_fail++; $display("FAIL decade_step[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=%b",
                           k, a_q, a_wrap, k % 10, (k == 10)); end
    end
    a_cnt = 0; tick();
    n_chk++; if (a_wrap !== 1'b0 || a_q !== 4'd0) begin
      n_fail++; $display("FAIL decade_pulse_end: Q=%0d wrap=%b, want 0 0", a_q, a_wrap); end
  endtask

  task automatic test_wrap_down_dir();
    a_cnt = 1; a_up = 0; tick();
    n_chk++; if (a_q !== 4'd9 || a_wrap !== 1'b1) begin
      n_fail++; $display("FAIL wrap_down: Q=%0d wrap=%b, want Q=9 wrap=1", a_q, a_wrap); end
    a_up = 1; tick();
    n_chk++; if (a_q !== 4'd0 || a_wrap !== 1'b1) begin
      n_fail++; $display("FAIL dir_change_up: Q=%0d wrap=%b, want Q=0 wrap=1", a_q, a_wrap); end
    a_up = 0; a_cnt = 0;
    a_load = 1; a_din = 4'd5; tick(); a_load = 0;
    a_cnt = 1; tick();
    n_chk++; if (a_q !== 4'd4 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL plain_down: Q=%0d wrap=%b, want Q=4 wrap=0", a_q, a_wrap); end
    idle_a();
  endtask

  task automatic test_saturate();
    int exp_q [5] = '{199, 200, 200, 200, 200};
    b_load = 1; b_din = 8'd198; tick(); b_load = 0;
    for (int k = 0; k < 5; k++) begin
      b_cnt = 1; b_up = 1; #1;
      n_chk++; if (b_tc !== (k >= 2)) begin
        n_fail++; $display("FAIL sat_tc[%0d]: tc=%b, want %b", k, b_tc, (k >= 2)); end
      tick();
      n_chk++; if (int'(b_q) !== exp_q[k] || b_wrap !== 1'b0) begin
        n_fail++; $display("FAIL sat_step[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=0",
                           k, b_q, b_wrap, exp_q[k]); end
    end
    b_load = 1; b_din = 8'd1; b_cnt = 0; tick(); b_load = 0;
    b_cnt = 1; b_up = 0; tick(); tick();
    n_chk++; if (b_q !== 8'd0 || b_wrap !== 1'b0 || b_tc !== 1'b1) begin
      n_fail++; $display("FAIL sat_floor: Q=%0d wrap=%b tc=%b, want 0 0 1", b_q, b_wrap, b_tc); end
    idle_b();
  endtask

  task automatic test_load_priority();
    a_load = 1; a_din = 4'd13; tick();
    n_chk++; if (a_q !== 4'd9) begin
      n_fail++; $display("FAIL load_clamp: Q=%0d, want 9", a_q); end
    a_set = 1; a_load = 1; a_cnt = 1; a_up = 1; a_din = 4'd3; tick();
    n_chk++; if (a_q !== 4'd9 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL set_load_cnt: Q=%0d wrap=%b, want Q=9 wrap=0", a_q, a_wrap); end
    a_set = 0; tick();
    n_chk++; if (a_q !== 4'd3 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_cnt: Q=%0d wrap=%b, want Q=3 wrap=0", a_q, a_wrap); end
    a_load = 1; a_cnt = 1; a_up = 0; a_din = 4'd9; a_set = 0;
    a_load = 1; a_din = 4'd0; tick();
    a_load = 0; a_set = 1; tick();
    n_chk++; if (a_q !== 4'd9 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL set_from_zero: Q=%0d wrap=%b, want Q=9 wrap=0", a_q, a_wrap); end
    idle_a();
  endtask

  task automatic test_reset_mid_pulse();
    a_load = 1; a_din = 4'd0; tick(); a_load = 0;
    a_cnt = 1; a_up = 0; tick();
    n_chk++; if (a_wrap !== 1'b1 || a_q !== 4'd9) begin
      n_fail++; $display("FAIL pre_reset_pulse: Q=%0d wrap=%b, want Q=9 wrap=1", a_q, a_wrap); end
    #2 clear_n = 0;
    #1;
    n_chk++; if (a_q !== 4'd0 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: Q=%0d wrap=%b, want 0 0", a_q, a_wrap); end
    #2 clear_n = 1; a_up = 1;
    tick();
    n_chk++; if (a_q !== 4'd1 || a_wrap !== 1'b0) begin
      n_fail++; $display("FAIL first_after_release: Q=%0d wrap=%b, want Q=1 wrap=0", a_q, a_wrap); end
    idle_a();
  endtask

  task automatic test_random();
    int qa = 0, qb = 0;
    bit wa, wb;
    clear_n = 0; #2 clear_n = 1;
    tick();
    for (int i = 0; i < 400; i++) begin
      a_set = ($urandom_range(0, 19) == 0); a_load = ($urandom_range(0, 9) == 0);
      a_cnt = ($urandom_range(0, 9) < 7);   a_up = $urandom_range(0, 1);
      a_din = 4'($urandom_range(0, 15));
      b_set = ($urandom_range(0, 19) == 0); b_load = ($urandom_range(0, 9) == 0);
      b_cnt = ($urandom_range(0, 9) < 7);   b_up = $urandom_range(0, 1);
      b_din = 8'($urandom_range(0, 255));
      #1;
      n_chk++; if (a_tc !== (a_cnt && (a_up ? qa == 9 : qa == 0))) begin
        n_fail++; $display("FAIL rnd_tc_a[%0d]: tc=%b q_model=%0d", i, a_tc, qa); end
      n_chk++; if (b_tc !== (b_cnt && (b_up ? qb == 200 : qb == 0))) begin
        n_fail++; $display("FAIL rnd_tc_b[%0d]: tc=%b q_model=%0d", i, b_tc, qb); end
      model(9, 0, a_set, a_load, a_cnt, a_up, int'(a_din), qa, wa);
      model(200, 1, b_set, b_load, b_cnt, b_up, int'(b_din), qb, wb);
      tick();
      n_chk++; if (int'(a_q) !== qa || a_wrap !== wa) begin
        n_fail++; $display("FAIL rnd_a[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=%b", i, a_q, a_wrap, qa, wa); end
      n_chk++; if (int'(b_q) !== qb || b_wrap !== wb) begin
        n_fail++; $display("FAIL rnd_b[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=%b", i, b_q, b_wrap, qb, wb); end
    end
    idle_a(); idle_b();
  endtask

  initial begin
    test_reset();
    test_set();
    test_decade_up();
    test_wrap_down_dir();
    test_saturate();
    test_load_priority();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_ud.md
# mod_counter_ud

Parametrised up/down modulo counter: the successor to the team's fixed 4-bit down counter with clear/set/count-enable. Adds configurable width and terminal value, direction control, parallel load, wrap-or-saturate mode, and terminal-count/wrap flags for cascading. Used as the general timing and sequencing counter in the lab designs, for example decade counters for display digits and cascaded prescalers.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 2..32.
- `MAX`, default 2**WIDTH-1: terminal value. Count range is 0..MAX. Must satisfy 1 ≤ MAX ≤ 2**WIDTH-1.
- `SATURATE`, default 0: 0 selects wrap mode, 1 selects saturate mode.
- `clk`, input, 1: clock, rising-edge active.
- `clear_n`, input, 1: reset. Asynchronous assert, active-low. Forces `Q` to 0 and clears `wrap`.
- `set`, input, 1: synchronous preset of `Q` to MAX.
- `load`, input, 1: synchronous parallel load from `din`.
- `din`, input, WIDTH: load value.
- `cnt`, input, 1: count enable.
- `up`, input, 1: direction. 1 counts up, 0 counts down.
- `Q`, output, WIDTH: current count. Registered.
- `tc`, output, 1: terminal count. Combinational. Equals `cnt & (up ? Q==MAX : Q==0)`.
- `wrap`, output, 1: registered one-cycle pulse in the cycle after a wrap.

## Operation
- Priority at each rising `clk`: `set` > `load` > `cnt` > hold. `clear_n` low overrides everything, asynchronously.
- `set`: `Q` ← MAX.
- `load`: `Q` ← `din` if `din` ≤ MAX, else `Q` ← MAX (clamped). Values above MAX are never stored.
- `cnt`, up:
  - `Q` < MAX: `Q` ← `Q`+1.
  - `Q` == MAX, wrap mode: `Q` ← 0.
  - `Q` == MAX, saturate mode: `Q` holds at MAX.
- `cnt`, down:
  - `Q` > 0: `Q` ← `Q`−1.
  - `Q` == 0, wrap mode: `Q` ← MAX.
  - `Q` == 0, saturate mode: `Q` holds at 0.
- Arithmetic is modulo MAX+1, never modulo 2**WIDTH. With MAX=9, up from 9 gives 0, not 10.
- `wrap` register: next value is 1 exactly when a count step takes the wrap branch. Otherwise 0.
  - Never asserts when SATURATE=1.
  - Never asserts on `set` or `load`, even if they move `Q` from MAX to 0 or from 0 to MAX.
- `tc` is asserted in both modes, and in saturate mode even while held. It drives the `cnt` of the next stage to build cascades.
- `up` may change on any cycle. The new direction takes effect on the next edge where `cnt` is high.

## Timing
- Reset values: `Q` = 0 and `wrap` = 0. `tc` follows from its inputs, so it is 1 exactly when `cnt`=1 and `up`=0.
- `clear_n` assertion is immediate, with no clock needed. On deassertion, the first counting edge is the first rising `clk` after `clear_n` goes high. The synchronizer lives outside this block.
- Reset during counting or during a `wrap` pulse: both drop to 0 immediately. No pending pulse survives reset.
- Latency:
  - `Q` updates one edge after `set`, `load` or `cnt` is sampled.
  - `wrap` goes high in the same cycle in which `Q` shows the wrapped value, and stays high for one cycle.
  - `tc` has zero latency.
- Simultaneous controls resolve by the priority above:
  - `set`+`load` → MAX.
  - `load`+`cnt` → `din`, with no count applied.
  - Neither of these cases pulses `wrap`.

## Structure
- Shared package `counter_pkg`:
  - Mode constants `CNT_WRAP`=0 and `CNT_SAT`=1.
  - Direction constants `CNT_DOWN`=0 and `CNT_UP`=1.
  - Used by this block and by prescaler and display users.
- No sub-module. Use:
  - one next-state combinational block computing the count step and the wrap decision;
  - one async-reset register block for `Q` and `wrap`;
  - one continuous assignment for `tc`.
- Elaboration-time check: report an error if MAX = 0 or MAX ≥ 2**WIDTH.

## Test plan
- Reset and preset, with WIDTH=4, MAX=9, wrap mode:
  - hold `clear_n`=0 → `Q`=0 and `wrap`=0 with no clock edge;
  - release, then pulse `set` → `Q`=9.
- Decade wrap up: from `Q`=0, `cnt`=1, `up`=1 for 10 edges → `Q` runs 1..9 then 0. `tc`=1 while `Q`=9, and `wrap`=1 only in the cycle showing `Q`=0.
- Wrap down and direction change:
  - from `Q`=0, `up`=0, one `cnt` edge → `Q`=9 and `wrap`=1;
  - then set `up`=1 for one edge → `Q`=0 and `wrap`=1.
- Saturate mode (SATURATE=1), WIDTH=8, MAX=200: load 198 and count up 5 edges → `Q`=199, 200, 200, 200, 200. `tc` stays 1 once `Q`=200, and `wrap` never asserts.
- Load clamp and priority, with MAX=9:
  - `load`=1 with `din`=13 → `Q`=9;
  - `set`+`load`+`cnt` with `din`=3 → `Q`=9;
  - `load`+`cnt` with `din`=3 → `Q`=3.
- Reset mid-pulse: assert `clear_n`=0 asynchronously in the cycle where `wrap`=1 → `wrap` and `Q` go to 0 immediately. The first edge after release with `cnt`=1 and `up`=1 gives `Q`=1.
